// File: rtl/bus_cycle_initiator_pkg.sv
// Shared definitions for the 8088-style multiplexed bus: cycle states, IOM encoding
// and the request record. Initiator and peripherals import this so both ends agree.
package bus_cycle_initiator_pkg;

    localparam int BUS_ADDR_W = 20;
    localparam int BUS_DATA_W = 8;

    localparam logic IOM_IO  = 1'b1;
    localparam logic IOM_MEM = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } bus_state_t;

    typedef struct packed {
        logic                  write;
        logic                  io;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_cycle_initiator_wait_timer.sv
// Wait-state counter: clear loads 1 (the first Tw), enable counts up, expired at MAX_WAIT.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count,
    output logic       expired
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd1;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == MAX_WAIT[7:0]);

endmodule

// File: rtl/bus_cycle_initiator.sv
// CPU-side bus interface unit: runs T1-T2-T3-(Tw)-T4 cycles on the multiplexed bus
// for single-byte requests taken over a valid/ready handshake.
module bus_cycle_initiator
    import bus_cycle_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_WAIT      = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_io,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     ALE,
    output logic                     RD,
    output logic                     WR,
    output logic                     IOM,
    output logic                     DTR,
    output logic                     DEN,
    output logic [ADDRESS_WIDTH-9:0] A,
    inout  wire  [DATA_WIDTH-1:0]    AD,
    input  logic                     READY,
    output logic [2:0]               dbg_state,
    output logic                     dbg_ad_oe,
    output logic [7:0]               dbg_wait_count
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("bus_cycle_initiator: MAX_WAIT must be in 1..255");
        end
        if (ADDRESS_WIDTH != BUS_ADDR_W || DATA_WIDTH != BUS_DATA_W) begin : g_bad_width
            $error("bus_cycle_initiator: widths must match bus_cycle_initiator_pkg");
        end
    endgenerate

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and T4, so T4 can chain straight into T1.
    bus_state_t             state, next_state;
    bus_req_t               req_q;
    logic                   abort_q;
    logic                   accept;
    logic                   timer_clear, timer_enable, timer_expired;
    logic [DATA_WIDTH-1:0]  ad_out;
    logic                   ad_oe;

    assign accept = req_valid && req_ready;

    bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .count   (dbg_wait_count),
        .expired (timer_expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            req_q     <= '0;
            abort_q   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_q <= '{write: req_write, io: req_io, addr: req_addr, wdata: req_wdata};
            end
            if (state == T1) begin
                abort_q <= 1'b0;
            end else if (state == TW && !READY && timer_expired) begin
                abort_q <= 1'b1;
            end
            // Data is taken only on the edge the peripheral says it is ready.
            if (!req_q.write && (state == T3 || state == TW) && READY) begin
                rsp_rdata <= AD;
            end
        end
    end

    always_comb begin
        next_state   = state;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state)
            IDLE:    next_state = accept ? T1 : IDLE;
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3: begin
                next_state  = READY ? T4 : TW;
                timer_clear = !READY;
            end
            TW: begin
                if (READY || timer_expired) begin
                    next_state = T4;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            T4:      next_state = accept ? T1 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        ALE       = 1'b0;
        RD        = 1'b1;
        WR        = 1'b1;
        DEN       = 1'b1;
        IOM       = IOM_MEM;
        DTR       = 1'b0;
        A         = '0;
        ad_oe     = 1'b0;
        ad_out    = '0;
        if (state != IDLE) begin
            IOM = req_q.io ? IOM_IO : IOM_MEM;
            DTR = req_q.write;
            A   = req_q.addr[ADDRESS_WIDTH-1:8];
        end
        case (state)
            IDLE: req_ready = 1'b1;
            T1: begin
                ALE    = 1'b1;
                ad_oe  = 1'b1;
                ad_out = req_q.addr[7:0];
            end
            T2, T3, TW: begin
                DEN    = 1'b0;
                RD     = req_q.write;
                WR     = !req_q.write;
                ad_oe  = req_q.write;
                ad_out = req_q.wdata;
            end
            T4: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                rsp_err   = abort_q;
                ad_oe     = req_q.write;
                ad_out    = req_q.wdata;
            end
            default: ;
        endcase
    end

    assign AD        = ad_oe ? ad_out : {DATA_WIDTH{1'bz}};
    assign dbg_state = state;
    assign dbg_ad_oe = ad_oe;

endmodule
